da_vinci_bus_monitor: RTL and testbench
=======================================

# da_vinci_bus_monitor

Passive observer on the DA_VINCI memory bus (ADDR/DATA/READ/WRITE), placed between the processor/memory pair and the testbench. It captures every processor write that falls inside a programmable address window into a show-ahead trace FIFO. It also keeps a write count and a rolling 32-bit signature, so benches can check a program's stores cycle-by-cycle instead of only through end-of-run memory dumps. It never drives the bus.

## Interface
Parameters:
- ADDR_W, 26, address width (matches the system address bus)
- DATA_W, 32, data width (matches the system data bus)
- DEPTH, 16, trace FIFO entries; power of two, minimum 2

Ports:
- CLK  in  1  system clock; all logic on the rising edge
- RST  in  1  synchronous, active-high reset
- ADDR  in  ADDR_W  bus address (observed only)
- DATA  in  DATA_W  bus data (observed only)
- READ  in  1  bus read strobe
- WRITE  in  1  bus write strobe
- WIN_LO  in  ADDR_W  window lower bound, inclusive
- WIN_HI  in  ADDR_W  window upper bound, inclusive
- ARM  in  1  single-cycle pulse: clear the trace and start capture
- STOP  in  1  single-cycle pulse: end capture
- POP  in  1  consume the head FIFO entry
- TRC_VALID  out  1  FIFO not empty
- TRC_ADDR  out  ADDR_W  head-entry address
- TRC_DATA  out  DATA_W  head-entry data
- COUNT  out  16  qualifying writes since ARM; saturates at 16'hFFFF
- SIGNATURE  out  32  rolling signature
- OVERFLOW  out  1  sticky: a record was dropped because the FIFO was full
- BUS_ERR  out  1  sticky: READ and WRITE were high in the same cycle
- CAPTURING  out  1  high in CAPTURE state

## Operation
- State machine: IDLE → CAPTURE on ARM. CAPTURE → DONE on STOP. DONE → CAPTURE on ARM. Reset → IDLE.
- ARM in any state: clears the FIFO, COUNT, SIGNATURE, OVERFLOW and BUS_ERR, then enters CAPTURE. ARM has priority over STOP in the same cycle. STOP outside CAPTURE is ignored.
- Write event: WRITE=1 this cycle and WRITE=0 in the previous sampled cycle (rising-edge detect). A strobe held for several cycles produces one event. The write-edge history register is cleared by reset.
- Qualifying write: a write event with READ=0, in CAPTURE, and WIN_LO ≤ ADDR ≤ WIN_HI (unsigned compare). If WIN_LO > WIN_HI, no write qualifies.
- READ=1 and WRITE=1 in the same cycle: sets BUS_ERR in every state except IDLE. The cycle is never recorded, but the edge-history register still updates.
- On a qualifying write:
  - push {ADDR, DATA};
  - COUNT += 1, saturating;
  - SIGNATURE ← {SIGNATURE[30:0], SIGNATURE[31]} ^ DATA ^ zero-extended ADDR.
- COUNT and SIGNATURE update even when the push is dropped.
- FIFO is show-ahead: TRC_ADDR/TRC_DATA are valid whenever TRC_VALID=1.
- POP with TRC_VALID=1 advances the head. POP on an empty FIFO is ignored.
- Full FIFO:
  - push without a simultaneous POP → record dropped, OVERFLOW←1;
  - push and POP in the same cycle → both succeed, no overflow.
- Pointers wrap modulo DEPTH. An occupancy counter (0..DEPTH) distinguishes full from empty.
- In DONE, COUNT and SIGNATURE hold and the FIFO can still be drained.

## Timing
- Reset values: TRC_VALID=0, TRC_ADDR=0, TRC_DATA=0, COUNT=0, SIGNATURE=0, OVERFLOW=0, BUS_ERR=0, CAPTURING=0. State=IDLE, FIFO empty.
- Latency: a qualifying write sampled at edge N is visible on TRC_*, COUNT and SIGNATURE after edge N (one cycle).
- POP sampled at edge N: the next entry, or TRC_VALID=0, appears after edge N.
- ARM sampled at edge N: CAPTURING=1 and all clears take effect after edge N. A write event at edge N is not recorded. Recording starts with events at edge N+1.
- STOP sampled at edge N: a write event at the same edge N is still recorded.
- RST mid-capture: everything returns to reset values on that edge. Entries in the FIFO are discarded.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Reset, WIN 0x1000000–0x100000F, ARM, then 4 single-cycle writes (0x1000000→0, 0x1000001→1, 0x1000002→1, 0x1000003→2) → COUNT=4, four entries popped in order, SIGNATURE equals the bench model's value, TRC_VALID=0 after the 4th POP.
- WRITE held 3 cycles at 0x1000005, then a write to 0x2000000 (outside the window) → exactly 1 entry, COUNT=1.
- DEPTH=16, 18 writes with no POP → 16 entries retained (the first 16), OVERFLOW=1, COUNT=18. Repeat with POP on the 17th write → no overflow at that write.
- READ=1 and WRITE=1 in the same cycle → BUS_ERR=1, no entry; a following ARM clears BUS_ERR.
- ARM and STOP in the same cycle while in DONE → CAPTURE state, counters cleared. STOP on the same edge as a write → that write is recorded, CAPTURING=0 next cycle.
- RST asserted mid-capture with 5 entries queued → all outputs at reset values next cycle, later writes ignored until ARM.

Source files
------------

// File: rtl/da_vinci_bus_monitor.sv
// Passive DA_VINCI bus observer: records windowed processor writes into a
// show-ahead trace FIFO and keeps a saturating write count and rolling signature.
module da_vinci_bus_monitor #(
  parameter int ADDR_W = 26,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] DATA,
  input  logic              READ,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] WIN_LO,
  input  logic [ADDR_W-1:0] WIN_HI,
  input  logic              ARM,
  input  logic              STOP,
  input  logic              POP,
  output logic              TRC_VALID,
  output logic [ADDR_W-1:0] TRC_ADDR,
  output logic [DATA_W-1:0] TRC_DATA,
  output logic [15:0]       COUNT,
  output logic [31:0]       SIGNATURE,
  output logic              OVERFLOW,
  output logic              BUS_ERR,
  output logic              CAPTURING
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  state_t            state, state_nxt;
  logic              wr_p1;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [OCC_W-1:0]  occ;
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic wr_evt, in_win, qual, full, pop_ok, push_ok, both;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [31:0] sig_next(input logic [31:0] s,
                                           input logic [DATA_W-1:0] d,
                                           input logic [ADDR_W-1:0] a);
    return {s[30:0], s[31]} ^ 32'(d) ^ 32'(a);
  endfunction

  always_comb begin
    state_nxt = state;
    if (ARM)
      state_nxt = CAPTURE;
    else if (STOP && state == CAPTURE)
      state_nxt = DONE;
  end

  // An inverted window (WIN_LO > WIN_HI) fails one of the two bounds by itself.
  assign wr_evt  = WRITE & ~wr_p1;
  assign both    = READ & WRITE;
  assign in_win  = (ADDR >= WIN_LO) && (ADDR <= WIN_HI);
  assign qual    = wr_evt & ~READ & (state == CAPTURE) & in_win & ~ARM;
  assign full    = (occ == OCC_W'(DEPTH));
  assign pop_ok  = POP & (occ != '0) & ~ARM;
  assign push_ok = qual & (~full | pop_ok);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      wr_p1     <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      COUNT     <= '0;
      SIGNATURE <= '0;
      OVERFLOW  <= 1'b0;
      BUS_ERR   <= 1'b0;
    end else begin
      state <= state_nxt;
      wr_p1 <= WRITE;
      if (ARM) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        occ       <= '0;
        COUNT     <= '0;
        SIGNATURE <= '0;
        OVERFLOW  <= 1'b0;
        BUS_ERR   <= 1'b0;
      end else begin
        if (qual) begin
          COUNT     <= sat_inc(COUNT);
          SIGNATURE <= sig_next(SIGNATURE, DATA, ADDR);
        end
        if (qual && full && !pop_ok)
          OVERFLOW <= 1'b1;
        if (both && state != IDLE)
          BUS_ERR <= 1'b1;
        if (push_ok)
          wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop_ok)
          rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push_ok, pop_ok})
          2'b10:   occ <= occ + OCC_W'(1);
          2'b01:   occ <= occ - OCC_W'(1);
          default: occ <= occ;
        endcase
      end
    end
  end

  // Trace storage carries no reset; occupancy alone decides what is live.
  always_ff @(posedge CLK) begin
    if (push_ok) begin
      addr_mem[wr_ptr] <= ADDR;
      data_mem[wr_ptr] <= DATA;
    end
  end

  assign TRC_VALID = (occ != '0);
  assign TRC_ADDR  = TRC_VALID ? addr_mem[rd_ptr] : '0;
  assign TRC_DATA  = TRC_VALID ? data_mem[rd_ptr] : '0;
  assign CAPTURING = (state == CAPTURE);

endmodule

// File: tb/tb_da_vinci_bus_monitor.sv
// Directed bench for da_vinci_bus_monitor: per-cycle vector table plus
// hand-written overflow and mid-capture reset sequences.
module tb_da_vinci_bus_monitor;

  localparam logic [25:0] LO = 26'h1000000;
  localparam logic [25:0] HI = 26'h100000F;

  logic        clk = 1'b0;
  logic        rst, read, write, arm, stop, pop;
  logic [25:0] addr, win_lo, win_hi;
  logic [31:0] data;
  logic        trc_valid, overflow, bus_err, capturing;
  logic [25:0] trc_addr;
  logic [31:0] trc_data, signature;
  logic [15:0] count;

  int ncmp = 0;
  int nfail = 0;

  da_vinci_bus_monitor #(.ADDR_W(26), .DATA_W(32), .DEPTH(16)) dut (
    .CLK(clk), .RST(rst), .ADDR(addr), .DATA(data), .READ(read), .WRITE(write),
    .WIN_LO(win_lo), .WIN_HI(win_hi), .ARM(arm), .STOP(stop), .POP(pop),
    .TRC_VALID(trc_valid), .TRC_ADDR(trc_addr), .TRC_DATA(trc_data),
    .COUNT(count), .SIGNATURE(signature), .OVERFLOW(overflow),
    .BUS_ERR(bus_err), .CAPTURING(capturing)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, arm, stop, pop, rd, wr;
    logic [25:0] addr;
    logic [31:0] data;
    logic [25:0] lo, hi;
    logic        vld;
    logic [25:0] taddr;
    logic [31:0] tdata;
    logic [15:0] cnt;
    logic [31:0] sig;
    logic        ovf, berr, cap;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, a, s, p, rd_i, wr_i,
                     input logic [25:0] ad, input logic [31:0] dt,
                     input logic [25:0] lo_i, hi_i,
                     input logic ev, input logic [25:0] eta, input logic [31:0] etd,
                     input logic [15:0] ec, input logic [31:0] es,
                     input logic eo, eb, ecap);
    vec_t v;
    v.rst = r; v.arm = a; v.stop = s; v.pop = p; v.rd = rd_i; v.wr = wr_i;
    v.addr = ad; v.data = dt; v.lo = lo_i; v.hi = hi_i;
    v.vld = ev; v.taddr = eta; v.tdata = etd; v.cnt = ec; v.sig = es;
    v.ovf = eo; v.berr = eb; v.cap = ecap;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic ev, input logic [25:0] eta,
                            input logic [31:0] etd, input logic [15:0] ec,
                            input logic [31:0] es, input logic eo, eb, ecap);
    chk({tag, ".valid"}, 32'(trc_valid), 32'(ev));
    chk({tag, ".addr"},  32'(trc_addr),  32'(eta));
    chk({tag, ".data"},  trc_data,       etd);
    chk({tag, ".count"}, 32'(count),     32'(ec));
    chk({tag, ".sig"},   signature,      es);
    chk({tag, ".ovf"},   32'(overflow),  32'(eo));
    chk({tag, ".berr"},  32'(bus_err),   32'(eb));
    chk({tag, ".cap"},   32'(capturing), 32'(ecap));
  endtask

  task automatic cyc(input logic r, a, s, p, rd_i, wr_i,
                     input logic [25:0] ad, input logic [31:0] dt);
    rst = r; arm = a; stop = s; pop = p; read = rd_i; write = wr_i;
    addr = ad; data = dt;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] sig_step(input logic [31:0] s, input logic [31:0] d,
                                           input logic [25:0] a);
    return {s[30:0], s[31]} ^ d ^ {6'b0, a};
  endfunction

  function automatic logic [25:0] ov_a(input int i);
    return 26'h1000020 + 26'(i);
  endfunction

  function automatic logic [31:0] ov_d(input int i);
    return 32'hA5A50000 + 32'(i);
  endfunction

  initial begin
    logic [31:0] msig;
    rst = 1'b1; arm = 1'b0; stop = 1'b0; pop = 1'b0; read = 1'b0; write = 1'b0;
    addr = '0; data = '0; win_lo = LO; win_hi = HI;

    //  rst arm stp pop rd wr addr          data          lo  hi   vld taddr        tdata  cnt sig           ovf berr cap
    add(1, 0, 0, 0, 0, 0, 26'h0,       32'h0,  LO, HI,  0, 26'h0,       32'h0,  0, 32'h0,        0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 26'h0,       32'h0,  LO, HI,  0, 26'h0,       32'h0,  0, 32'h0,        0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 26'h0,       32'h0,  LO, HI,  0, 26'h0,       32'h0,  0, 32'h0,        0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 26'h1000000, 32'h0,  LO, HI,  1, 26'h1000000, 32'h0,  1, 32'h01000000, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 26'h0,       32'h0,  LO, HI,  1, 26'h1000000, 32'h0,  1, 32'h01000000, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 26'h1000001, 32'h1,  LO, HI,  1, 26'h1000000, 32'h0,  2, 32'h03000000, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 26'h0,       32'h0,  LO, HI,  1, 26'h1000000, 32'h0,  2, 32'h03000000, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 26'h1000002, 32'h1,  LO, HI,  1, 26'h1000000, 32'h0,  3, 32'h07000003, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 26'h0,       32'h0,  LO, HI,  1, 26'h1000000, 32'h0,  3, 32'h07000003, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 26'h1000003, 32'h2,  LO, HI,  1, 26'h1000000, 32'h0,  4, 32'h0F000007, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0, 26'h0,       32'h0,  LO, HI,  1, 26'h1000001, 32'h1,  4, 32'h0F000007, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0, 26'h0,       32'h0,  LO, HI,  1, 26'h1000002, 32'h1,  4, 32'h0F000007, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0, 26'h0,       32'h0,  LO, HI,  1, 26'h1000003, 32'h2,  4, 32'h0F000007, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0, 26'h0,       32'h0,  LO, HI,  0, 26'h0,       32'h0,  4, 32'h0F000007, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0, 26'h0,       32'h0,  LO, HI,  0, 26'h0,       32'h0,  4, 32'h0F000007, 0, 0, 1);
    // held strobe and out-of-window write
    add(0, 1, 0, 0, 0, 0, 26'h0,       32'h0,  LO, HI,  0, 26'h0,       32'h0,  0, 32'h0,        0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 26'h1000005, 32'hAA, LO, HI,  1, 26'h1000005, 32'hAA, 1, 32'h010000AF, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 26'h1000005, 32'hAA, LO, HI,  1, 26'h1000005, 32'hAA, 1, 32'h010000AF, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 26'h1000005, 32'hAA, LO, HI,  1, 26'h1000005, 32'hAA, 1, 32'h010000AF, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 26'h0,       32'h0,  LO, HI,  1, 26'h1000005, 32'hAA, 1, 32'h010000AF, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 26'h2000000, 32'h55, LO, HI,  1, 26'h1000005, 32'hAA, 1, 32'h010000AF, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0, 26'h0,       32'h0,  LO, HI,  0, 26'h0,       32'h0,  1, 32'h010000AF, 0, 0, 1);
    // read and write together
    add(0, 0, 0, 0, 0, 0, 26'h0,       32'h0,  LO, HI,  0, 26'h0,       32'h0,  1, 32'h010000AF, 0, 0, 1);
    add(0, 0, 0, 0, 1, 1, 26'h1000006, 32'h11, LO, HI,  0, 26'h0,       32'h0,  1, 32'h010000AF, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 26'h0,       32'h0,  LO, HI,  0, 26'h0,       32'h0,  1, 32'h010000AF, 0, 1, 1);
    add(0, 1, 0, 0, 0, 0, 26'h0,       32'h0,  LO, HI,  0, 26'h0,       32'h0,  0, 32'h0,        0, 0, 1);
    // STOP with a write, DONE behaviour, ARM+STOP, ARM with a write
    add(0, 0, 1, 0, 0, 1, 26'h1000007, 32'h3,  LO, HI,  1, 26'h1000007, 32'h3,  1, 32'h01000004, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 26'h0,       32'h0,  LO, HI,  1, 26'h1000007, 32'h3,  1, 32'h01000004, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 26'h1000008, 32'h4,  LO, HI,  1, 26'h1000007, 32'h3,  1, 32'h01000004, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 26'h0,       32'h0,  LO, HI,  0, 26'h0,       32'h0,  0, 32'h0,        0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 26'h1000009, 32'h5,  LO, HI,  1, 26'h1000009, 32'h5,  1, 32'h0100000C, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 26'h0,       32'h0,  LO, HI,  1, 26'h1000009, 32'h5,  1, 32'h0100000C, 0, 0, 1);
    add(0, 1, 0, 0, 0, 1, 26'h100000A, 32'h6,  LO, HI,  0, 26'h0,       32'h0,  0, 32'h0,        0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 26'h0,       32'h0,  LO, HI,  0, 26'h0,       32'h0,  0, 32'h0,        0, 0, 1);
    // inverted window, then window edges
    add(0, 0, 0, 0, 0, 1, 26'h1000008, 32'h7,  HI, LO,  0, 26'h0,       32'h0,  0, 32'h0,        0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 26'h0,       32'h0,  HI, LO,  0, 26'h0,       32'h0,  0, 32'h0,        0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 26'h100000F, 32'h0,  LO, HI,  1, 26'h100000F, 32'h0,  1, 32'h0100000F, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 26'h0,       32'h0,  LO, HI,  1, 26'h100000F, 32'h0,  1, 32'h0100000F, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 26'h1000010, 32'h9,  LO, HI,  1, 26'h100000F, 32'h0,  1, 32'h0100000F, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0, 26'h0,       32'h0,  LO, HI,  0, 26'h0,       32'h0,  1, 32'h0100000F, 0, 0, 1);

    foreach (tbl[i]) begin
      win_lo = tbl[i].lo;
      win_hi = tbl[i].hi;
      cyc(tbl[i].rst, tbl[i].arm, tbl[i].stop, tbl[i].pop, tbl[i].rd, tbl[i].wr,
          tbl[i].addr, tbl[i].data);
      check_outs($sformatf("vec%0d", i), tbl[i].vld, tbl[i].taddr, tbl[i].tdata,
                 tbl[i].cnt, tbl[i].sig, tbl[i].ovf, tbl[i].berr, tbl[i].cap);
    end

    // Overflow: 18 writes into 16 entries, nothing popped
    win_lo = 26'h1000000; win_hi = 26'h10000FF;
    cyc(0, 1, 0, 0, 0, 0, '0, '0);
    msig = '0;
    for (int i = 0; i < 18; i++) begin
      cyc(0, 0, 0, 0, 0, 1, ov_a(i), ov_d(i));
      msig = sig_step(msig, ov_d(i), ov_a(i));
      cyc(0, 0, 0, 0, 0, 0, '0, '0);
    end
    chk("ovf.count", 32'(count), 32'd18);
    chk("ovf.flag", 32'(overflow), 32'd1);
    chk("ovf.sig", signature, msig);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("ovf.head%0d.addr", i), 32'(trc_addr), 32'(ov_a(i)));
      chk($sformatf("ovf.head%0d.data", i), trc_data, ov_d(i));
      cyc(0, 0, 0, 1, 0, 0, '0, '0);
    end
    chk("ovf.drained", 32'(trc_valid), 32'd0);

    // Full FIFO with a POP on the 17th write, then a plain 18th write
    cyc(0, 1, 0, 0, 0, 0, '0, '0);
    chk("ovf2.arm_clears", 32'(overflow), 32'd0);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 0, 0, 0, 1, ov_a(i), ov_d(i));
      cyc(0, 0, 0, 0, 0, 0, '0, '0);
    end
    cyc(0, 0, 0, 1, 0, 1, ov_a(16), ov_d(16));
    chk("ovf2.pop17.flag", 32'(overflow), 32'd0);
    chk("ovf2.pop17.count", 32'(count), 32'd17);
    chk("ovf2.pop17.head", 32'(trc_addr), 32'(ov_a(1)));
    cyc(0, 0, 0, 0, 0, 0, '0, '0);
    cyc(0, 0, 0, 0, 0, 1, ov_a(17), ov_d(17));
    chk("ovf2.w18.flag", 32'(overflow), 32'd1);
    chk("ovf2.w18.count", 32'(count), 32'd18);
    for (int i = 1; i < 17; i++) begin
      chk($sformatf("ovf2.head%0d.data", i), trc_data, ov_d(i));
      cyc(0, 0, 0, 1, 0, 0, '0, '0);
    end
    chk("ovf2.drained", 32'(trc_valid), 32'd0);

    // RST in the middle of a capture with 5 entries queued
    cyc(0, 1, 0, 0, 0, 0, '0, '0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0, 0, 1, ov_a(i), ov_d(i));
      cyc(0, 0, 0, 0, 0, 0, '0, '0);
    end
    chk("rst.pre.count", 32'(count), 32'd5);
    cyc(1, 0, 0, 0, 0, 0, '0, '0);
    check_outs("rst.after", 0, 26'h0, 32'h0, 16'd0, 32'h0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, ov_a(7), ov_d(7));
    cyc(0, 0, 0, 0, 0, 0, '0, '0);
    cyc(0, 0, 0, 0, 1, 1, ov_a(8), ov_d(8));
    cyc(0, 0, 0, 0, 0, 0, '0, '0);
    check_outs("rst.idle", 0, 26'h0, 32'h0, 16'd0, 32'h0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, '0, '0);
    cyc(0, 0, 0, 0, 0, 1, ov_a(9), ov_d(9));
    check_outs("rst.rearm", 1, ov_a(9), ov_d(9), 16'd1,
               sig_step(32'h0, ov_d(9), ov_a(9)), 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
